// File: rtl/vpu_lane_pipe.sv
// Pipelined multi-lane integer vector unit: one op per beat across LANE_CNT lanes,
// masked sources, valid/ready flow control and per-lane sum/max reduction across beats.
module vpu_lane_pipe #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned LANE_CNT    = 4,
    parameter int unsigned SRC_CNT     = 3,
    parameter int unsigned PIPE_STAGES = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid_i,
    output logic                                   in_ready_o,
    input  logic [2:0]                             op_i,
    input  logic                                   signed_i,
    input  logic [SRC_CNT*LANE_CNT*DATA_WIDTH-1:0] operand_i,
    input  logic [SRC_CNT-1:0]                     operand_valid_i,
    input  logic                                   acc_first_i,
    input  logic                                   acc_last_i,
    output logic                                   out_valid_o,
    input  logic                                   out_ready_i,
    output logic [LANE_CNT*DATA_WIDTH-1:0]         dout_o,
    output logic [LANE_CNT-1:0]                    overflow_o,
    output logic                                   busy_o
);

    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned XW = DATA_WIDTH + 2;
    localparam logic [XW-1:0] Three = XW'(3);

    typedef enum logic [2:0] {
        OpAdd, OpSub, OpMul, OpMax, OpMin, OpAvg, OpAccAdd, OpAccMax
    } op_e;

    typedef struct packed {
        logic [W-1:0] res;
        logic         ovf;
    } lane_res_t;

    typedef struct packed {
        logic                  valid;
        logic                  is_acc;
        logic                  acc_max;
        logic                  first;
        logic                  last;
        logic                  sgn;
        logic [LANE_CNT-1:0]   ovf;
        logic [LANE_CNT*W-1:0] res;
    } stage_t;

    function automatic logic fits_signed(input logic [2:0] top);
        return (top == 3'b000) || (top == 3'b111);
    endfunction

    function automatic lane_res_t lane_calc(
        input logic [2:0]           op,
        input logic                 sgn,
        input logic [SRC_CNT-1:0]   msk,
        input logic [SRC_CNT*W-1:0] ops
    );
        logic [XW-1:0]  ext [SRC_CNT];
        logic [XW-1:0]  sum;
        logic [XW-1:0]  diff;
        logic [XW-1:0]  mag;
        logic [XW-1:0]  quo;
        logic [2*W-1:0] pa;
        logic [2*W-1:0] pb;
        logic [2*W-1:0] prod;
        logic [W:0]     best;
        logic [W:0]     cand;
        logic           have;
        logic           neg;
        logic           better;
        logic [1:0]     cnt;
        lane_res_t      r;

        r    = '0;
        sum  = '0;
        cnt  = '0;
        best = '0;
        have = 1'b0;
        for (int s = 0; s < SRC_CNT; s++) begin
            ext[s] = sgn ? {{2{ops[s*W+W-1]}}, ops[s*W +: W]} : {2'b00, ops[s*W +: W]};
        end
        // Sum, count and extremum over the masked sources; W+1 bits is enough to order them.
        for (int s = 0; s < SRC_CNT; s++) begin
            if (msk[s]) begin
                sum  = sum + ext[s];
                cnt  = cnt + 2'd1;
                cand = ext[s][W:0];
                better = (op == OpMin) ? ($signed(cand) < $signed(best))
                                       : ($signed(cand) > $signed(best));
                if (!have || better) begin
                    best = cand;
                end
                have = 1'b1;
            end
        end
        diff = ext[0] - ext[1] - (msk[2] ? ext[2] : '0);
        pa   = sgn ? {{W{ops[W-1]}}, ops[0 +: W]} : {{W{1'b0}}, ops[0 +: W]};
        pb   = sgn ? {{W{ops[2*W-1]}}, ops[W +: W]} : {{W{1'b0}}, ops[W +: W]};
        prod = pa * pb;
        neg  = sgn & sum[XW-1];
        mag  = neg ? (~sum + 1'b1) : sum;
        quo  = (cnt == 2'd3) ? (mag / Three) : (cnt == 2'd2) ? (mag >> 1) : mag;
        quo  = neg ? (~quo + 1'b1) : quo;

        case (op)
            OpAdd, OpAccAdd: begin
                r.res = sum[W-1:0];
                r.ovf = sgn ? !fits_signed(sum[XW-1:W-1]) : |sum[XW-1:W];
            end
            OpSub: begin
                if (msk[1:0] == 2'b11) begin
                    r.res = diff[W-1:0];
                    r.ovf = sgn ? !fits_signed(diff[XW-1:W-1]) : diff[XW-1];
                end
            end
            OpMul: begin
                if (msk[1:0] == 2'b11) begin
                    r.res = prod[W-1:0];
                    r.ovf = sgn ? (prod[2*W-1:W] != {W{prod[W-1]}}) : |prod[2*W-1:W];
                end
            end
            OpMax, OpMin, OpAccMax: begin
                r.res = best[W-1:0];
            end
            OpAvg: begin
                if (cnt != 2'd0) begin
                    r.res = quo[W-1:0];
                end
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    logic                                adv;
    logic [LANE_CNT-1:0][SRC_CNT*W-1:0]  lane_ops;
    stage_t                              in_stage;
    stage_t                              fin_in;
    logic                                mid_busy;

    logic                                out_valid_q, out_valid_d;
    logic [LANE_CNT*W-1:0]               dout_q, dout_d;
    logic [LANE_CNT-1:0]                 ovf_q, ovf_d;
    logic [LANE_CNT*W-1:0]               acc_q, acc_d;
    logic [LANE_CNT-1:0]                 acc_ovf_q, acc_ovf_d;
    logic                                acc_open_q, acc_open_d;
    logic [LANE_CNT*W-1:0]               acc_nv;
    logic [LANE_CNT-1:0]                 acc_no;

    assign adv        = !out_valid_q || out_ready_i;
    assign in_ready_o = adv;

    always_comb begin
        for (int l = 0; l < LANE_CNT; l++) begin
            for (int s = 0; s < SRC_CNT; s++) begin
                lane_ops[l][s*W +: W] = operand_i[(s*LANE_CNT+l)*W +: W];
            end
        end
    end

    always_comb begin
        lane_res_t lr;
        in_stage         = '0;
        in_stage.valid   = in_valid_i;
        in_stage.is_acc  = (op_i == OpAccAdd) || (op_i == OpAccMax);
        in_stage.acc_max = (op_i == OpAccMax);
        in_stage.first   = acc_first_i;
        in_stage.last    = acc_last_i;
        in_stage.sgn     = signed_i;
        for (int l = 0; l < LANE_CNT; l++) begin
            lr = lane_calc(op_i, signed_i, operand_valid_i, lane_ops[l]);
            in_stage.res[l*W +: W] = lr.res;
            in_stage.ovf[l]        = lr.ovf;
        end
    end

    generate
        if (PIPE_STAGES > 1) begin : g_mid
            stage_t mid_q [PIPE_STAGES-1];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < PIPE_STAGES - 1; i++) begin
                        mid_q[i] <= '0;
                    end
                end else if (adv) begin
                    mid_q[0] <= in_stage;
                    for (int i = 1; i < PIPE_STAGES - 1; i++) begin
                        mid_q[i] <= mid_q[i-1];
                    end
                end
            end

            always_comb begin
                mid_busy = 1'b0;
                for (int i = 0; i < PIPE_STAGES - 1; i++) begin
                    mid_busy = mid_busy | mid_q[i].valid;
                end
            end

            assign fin_in = mid_q[PIPE_STAGES-2];
        end else begin : g_direct
            assign fin_in   = in_stage;
            assign mid_busy = 1'b0;
        end
    endgenerate

    // Fold the beat leaving the last mid stage into the per-lane accumulator.
    always_comb begin
        logic         fresh;
        logic         gt;
        logic [W-1:0] a_v;
        logic [W-1:0] b_v;
        logic [W:0]   s_v;
        fresh  = fin_in.first || !acc_open_q;
        acc_nv = '0;
        acc_no = '0;
        for (int l = 0; l < LANE_CNT; l++) begin
            a_v = acc_q[l*W +: W];
            b_v = fin_in.res[l*W +: W];
            s_v = {1'b0, a_v} + {1'b0, b_v};
            gt  = fin_in.sgn ? ($signed(b_v) > $signed(a_v)) : (b_v > a_v);
            if (fresh) begin
                acc_nv[l*W +: W] = b_v;
                acc_no[l]        = fin_in.ovf[l];
            end else if (fin_in.acc_max) begin
                acc_nv[l*W +: W] = gt ? b_v : a_v;
                acc_no[l]        = acc_ovf_q[l] | fin_in.ovf[l];
            end else begin
                acc_nv[l*W +: W] = s_v[W-1:0];
                acc_no[l]        = acc_ovf_q[l] | fin_in.ovf[l] |
                                   (fin_in.sgn ? ((a_v[W-1] == b_v[W-1]) &&
                                                  (s_v[W-1] != a_v[W-1]))
                                               : s_v[W]);
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        dout_d      = dout_q;
        ovf_d       = ovf_q;
        acc_d       = acc_q;
        acc_ovf_d   = acc_ovf_q;
        acc_open_d  = acc_open_q;
        if (adv) begin
            out_valid_d = 1'b0;
            if (fin_in.valid) begin
                if (!fin_in.is_acc) begin
                    out_valid_d = 1'b1;
                    dout_d      = fin_in.res;
                    ovf_d       = fin_in.ovf;
                end else begin
                    acc_d      = acc_nv;
                    acc_ovf_d  = acc_no;
                    acc_open_d = !fin_in.last;
                    if (fin_in.last) begin
                        out_valid_d = 1'b1;
                        dout_d      = acc_nv;
                        ovf_d       = acc_no;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            ovf_q       <= '0;
            acc_q       <= '0;
            acc_ovf_q   <= '0;
            acc_open_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            dout_q      <= dout_d;
            ovf_q       <= ovf_d;
            acc_q       <= acc_d;
            acc_ovf_q   <= acc_ovf_d;
            acc_open_q  <= acc_open_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign dout_o      = dout_q;
    assign overflow_o  = ovf_q;
    assign busy_o      = mid_busy || out_valid_q || acc_open_q;

endmodule

// File: tb/tb_vpu_lane_pipe.sv
// Directed bench for vpu_lane_pipe at DATA_WIDTH=8, LANE_CNT=2, PIPE_STAGES=2.
module tb_vpu_lane_pipe;

    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2, OP_MAX = 3'd3;
    localparam logic [2:0] OP_MIN = 3'd4, OP_AVG = 3'd5, OP_ACC_ADD = 3'd6, OP_ACC_MAX = 3'd7;

    typedef struct packed {
        logic [2:0]  op;
        logic        sgn;
        logic [2:0]  mask;
        logic [47:0] opnd;
        logic        first;
        logic        last;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [2:0]  op_i;
    logic        signed_i;
    logic [47:0] operand_i;
    logic [2:0]  operand_valid_i;
    logic        acc_first_i;
    logic        acc_last_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [15:0] dout_o;
    logic [1:0]  overflow_o;
    logic        busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    beat_t       bq[$];
    logic [15:0] exp_d[$];
    logic [15:0] cap_d[$];
    logic [1:0]  exp_o[$];
    logic [1:0]  cap_o[$];

    vpu_lane_pipe #(
        .DATA_WIDTH (8),
        .LANE_CNT   (2),
        .SRC_CNT    (3),
        .PIPE_STAGES(2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .op_i           (op_i),
        .signed_i       (signed_i),
        .operand_i      (operand_i),
        .operand_valid_i(operand_valid_i),
        .acc_first_i    (acc_first_i),
        .acc_last_i     (acc_last_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .dout_o         (dout_o),
        .overflow_o     (overflow_o),
        .busy_o         (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Operands listed as lane0 s0..s2 then lane1 s0..s2.
    function automatic logic [47:0] pk(input logic [7:0] a0, input logic [7:0] a1,
                                       input logic [7:0] a2, input logic [7:0] b0,
                                       input logic [7:0] b1, input logic [7:0] b2);
        return {b2, a2, b1, a1, b0, a0};
    endfunction

    function automatic beat_t mk(input logic [2:0] op, input logic sgn, input logic [2:0] mask,
                                 input logic [47:0] opnd, input logic first, input logic last);
        beat_t b;
        b.op = op; b.sgn = sgn; b.mask = mask; b.opnd = opnd; b.first = first; b.last = last;
        return b;
    endfunction

    task automatic drive(input beat_t b);
        in_valid_i      = 1'b1;
        op_i            = b.op;
        signed_i        = b.sgn;
        operand_valid_i = b.mask;
        operand_i       = b.opnd;
        acc_first_i     = b.first;
        acc_last_i      = b.last;
    endtask

    task automatic want(input logic [15:0] d, input logic [1:0] o);
        exp_d.push_back(d);
        exp_o.push_back(o);
    endtask

    // Streams bq back-to-back, optionally dropping out_ready_i for stall_len cycles.
    task automatic run_stream(input int stall_at, input int stall_len);
        int          tx;
        logic        stalled_prev;
        logic [15:0] held_d;
        logic [1:0]  held_o;
        tx = 0;
        stalled_prev = 1'b0;
        held_d = '0;
        held_o = '0;
        for (int c = 0; c < bq.size() + stall_len + 8; c++) begin
            out_ready_i = !(c >= stall_at && c < stall_at + stall_len);
            if (tx < bq.size()) drive(bq[tx]);
            else in_valid_i = 1'b0;
            #1;
            if (out_valid_o && !out_ready_i) begin
                check("stall_in_ready", {31'd0, in_ready_o}, 32'd0);
                if (stalled_prev) begin
                    check("stall_dout_hold", {16'd0, dout_o}, {16'd0, held_d});
                    check("stall_ovf_hold", {30'd0, overflow_o}, {30'd0, held_o});
                end
                held_d = dout_o;
                held_o = overflow_o;
                stalled_prev = 1'b1;
            end else begin
                stalled_prev = 1'b0;
            end
            if (out_valid_o && out_ready_i) begin
                cap_d.push_back(dout_o);
                cap_o.push_back(overflow_o);
            end
            if (in_valid_i && in_ready_o) tx++;
            tick();
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        check("stream_all_accepted", tx, bq.size());
        bq.delete();
    endtask

    task automatic compare(input string tag);
        check({tag, "_count"}, cap_d.size(), exp_d.size());
        for (int i = 0; i < exp_d.size() && i < cap_d.size(); i++) begin
            check($sformatf("%s_dout[%0d]", tag, i), {16'd0, cap_d[i]}, {16'd0, exp_d[i]});
            check($sformatf("%s_ovf[%0d]", tag, i), {30'd0, cap_o[i]}, {30'd0, exp_o[i]});
        end
        exp_d.delete(); exp_o.delete(); cap_d.delete(); cap_o.delete();
    endtask

    initial begin
        rst = 1'b1; in_valid_i = 1'b0; op_i = '0; signed_i = 1'b0; operand_i = '0;
        operand_valid_i = '0; acc_first_i = 1'b0; acc_last_i = 1'b0; out_ready_i = 1'b1;
        tick();
        tick();
        check("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
        check("rst_dout", {16'd0, dout_o}, 32'd0);
        check("rst_ovf", {30'd0, overflow_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        rst = 1'b0;
        tick();

        // Latency: accepted at one edge, visible after the second.
        drive(mk(OP_ADD, 1'b0, 3'b011, pk(8'd10, 8'd20, 8'h55, 8'd250, 8'd10, 8'h55), 0, 0));
        #1;
        check("lat_in_ready", {31'd0, in_ready_o}, 32'd1);
        tick();
        in_valid_i = 1'b0;
        check("lat_cycle1_idle", {31'd0, out_valid_o}, 32'd0);
        tick();
        check("lat_cycle2_valid", {31'd0, out_valid_o}, 32'd1);
        check("lat_dout", {16'd0, dout_o}, 32'h041E);
        check("lat_ovf", {30'd0, overflow_o}, 32'b10);
        tick();
        check("lat_drained", {31'd0, out_valid_o}, 32'd0);
        check("lat_busy", {31'd0, busy_o}, 32'd0);

        // Arithmetic mix, back-to-back.
        bq.push_back(mk(OP_SUB, 1, 3'b111, pk(8'h80, 8'd1, 8'd1, 8'd5, 8'd3, 8'd1), 0, 0));
        want(16'h017E, 2'b01);
        bq.push_back(mk(OP_AVG, 1, 3'b111, pk(8'hF9, 8'd2, 8'd0, 8'd10, 8'hFB, 8'd1), 0, 0));
        want(16'h02FF, 2'b00);
        bq.push_back(mk(OP_AVG, 0, 3'b011, pk(8'd7, 8'd2, 8'd99, 8'hFF, 8'hFF, 8'd9), 0, 0));
        want(16'hFF04, 2'b00);
        bq.push_back(mk(OP_MAX, 1, 3'b000, pk(8'd7, 8'd2, 8'd9, 8'd3, 8'd4, 8'd5), 0, 0));
        want(16'h0000, 2'b00);
        bq.push_back(mk(OP_SUB, 0, 3'b101, pk(8'd9, 8'd1, 8'd1, 8'd0, 8'd7, 8'd7), 0, 0));
        want(16'h0000, 2'b00);
        bq.push_back(mk(OP_MIN, 0, 3'b111, pk(8'd200, 8'd3, 8'd50, 8'h80, 8'h7F, 8'h90), 0, 0));
        want(16'h7F03, 2'b00);
        bq.push_back(mk(OP_MIN, 1, 3'b111, pk(8'd200, 8'd3, 8'd50, 8'h80, 8'h7F, 8'h90), 0, 0));
        want(16'h80C8, 2'b00);
        run_stream(0, 0);
        compare("arith");

        // Signed MUL stream with a 3-cycle downstream stall.
        bq.push_back(mk(OP_MUL, 1, 3'b011, pk(8'd16, 8'd8, 0, 8'd3, 8'd4, 0), 0, 0));
        want(16'h0C80, 2'b01);
        bq.push_back(mk(OP_MUL, 1, 3'b011, pk(8'hFE, 8'd3, 0, 8'd5, 8'd5, 0), 0, 0));
        want(16'h19FA, 2'b00);
        bq.push_back(mk(OP_MUL, 1, 3'b011, pk(8'hF0, 8'd8, 0, 8'd1, 8'd1, 0), 0, 0));
        want(16'h0180, 2'b00);
        bq.push_back(mk(OP_MUL, 1, 3'b011, pk(8'd127, 8'd2, 0, 8'hFF, 8'hFF, 0), 0, 0));
        want(16'h01FE, 2'b01);
        bq.push_back(mk(OP_MUL, 1, 3'b011, pk(8'd0, 8'd99, 0, 8'd10, 8'd10, 0), 0, 0));
        want(16'h6400, 2'b00);
        bq.push_back(mk(OP_MUL, 1, 3'b011, pk(8'h80, 8'hFF, 0, 8'd7, 8'hFD, 0), 0, 0));
        want(16'hEB80, 2'b01);
        run_stream(3, 3);
        compare("mul_bp");

        // Signed ACC_MAX over four beats.
        bq.push_back(mk(OP_ACC_MAX, 1, 3'b001, pk(8'd3, 0, 0, 8'hF6, 0, 0), 1, 0));
        bq.push_back(mk(OP_ACC_MAX, 1, 3'b001, pk(8'hFB, 0, 0, 8'hEC, 0, 0), 0, 0));
        bq.push_back(mk(OP_ACC_MAX, 1, 3'b001, pk(8'd9, 0, 0, 8'hFD, 0, 0), 0, 0));
        bq.push_back(mk(OP_ACC_MAX, 1, 3'b001, pk(8'd1, 0, 0, 8'hF9, 0, 0), 0, 1));
        want(16'hFD09, 2'b00);
        run_stream(0, 0);
        compare("acc_max");

        // Unsigned ACC_ADD wrapping 200+100.
        bq.push_back(mk(OP_ACC_ADD, 0, 3'b001, pk(8'd200, 0, 0, 8'd1, 0, 0), 1, 0));
        bq.push_back(mk(OP_ACC_ADD, 0, 3'b001, pk(8'd100, 0, 0, 8'd2, 0, 0), 0, 1));
        want(16'h032C, 2'b01);
        run_stream(0, 0);
        compare("acc_add");

        // Plain ADD inside an open reduction; its acc flags are ignored.
        bq.push_back(mk(OP_ACC_ADD, 0, 3'b001, pk(8'd5, 0, 0, 8'd0, 0, 0), 1, 0));
        bq.push_back(mk(OP_ADD, 0, 3'b011, pk(8'd1, 8'd1, 0, 8'd2, 8'd3, 0), 1, 0));
        bq.push_back(mk(OP_ACC_ADD, 0, 3'b001, pk(8'd7, 0, 0, 8'd4, 0, 0), 0, 1));
        want(16'h0502, 2'b00);
        want(16'h040C, 2'b00);
        run_stream(0, 0);
        compare("interleave");

        // A second acc_first discards the partial sum.
        bq.push_back(mk(OP_ACC_ADD, 0, 3'b001, pk(8'd50, 0, 0, 8'd10, 0, 0), 1, 0));
        bq.push_back(mk(OP_ACC_ADD, 0, 3'b001, pk(8'd60, 0, 0, 8'd20, 0, 0), 0, 0));
        bq.push_back(mk(OP_ACC_ADD, 0, 3'b001, pk(8'd3, 0, 0, 8'd1, 0, 0), 1, 0));
        bq.push_back(mk(OP_ACC_ADD, 0, 3'b001, pk(8'd4, 0, 0, 8'd2, 0, 0), 0, 1));
        want(16'h0307, 2'b00);
        run_stream(0, 0);
        compare("restart");

        // Reset with a reduction open and two beats in flight.
        drive(mk(OP_ACC_ADD, 0, 3'b001, pk(8'd9, 0, 0, 8'd1, 0, 0), 1, 0));
        tick();
        drive(mk(OP_ADD, 0, 3'b011, pk(8'd1, 8'd1, 0, 8'd1, 8'd1, 0), 0, 0));
        tick();
        tick();
        in_valid_i = 1'b0;
        check("pre_rst_busy", {31'd0, busy_o}, 32'd1);
        rst = 1'b1;
        tick();
        check("mid_rst_out_valid", {31'd0, out_valid_o}, 32'd0);
        check("mid_rst_busy", {31'd0, busy_o}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("post_rst_quiet[%0d]", i), {31'd0, out_valid_o}, 32'd0);
            tick();
        end
        bq.push_back(mk(OP_ACC_ADD, 0, 3'b001, pk(8'd11, 0, 0, 8'd2, 0, 0), 0, 1));
        want(16'h020B, 2'b00);
        run_stream(0, 0);
        compare("post_rst_acc");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
